// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the multiply-sequencer state encoding.
`default_nettype none

package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/mul_sequencer.sv
// Shift-add XLEN x XLEN -> 2*XLEN unsigned multiplier that borrows the shared ALU
// for one add per cycle; the ALU carry-out becomes the top bit of the partial product.
`default_nettype none

module mul_sequencer
   import alu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] alu_x,
   output logic [XLEN-1:0] alu_y,
   output logic [3:0]      alu_ctrl,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_cout,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] prod_hi,
   output logic [XLEN-1:0] prod_lo
);

   localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   mul_state_t      state;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] mcand;
   logic [CW-1:0]   cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         hi    <= '0;
         lo    <= '0;
         mcand <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  hi    <= '0;
                  lo    <= b;
                  mcand <= a;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               // Sum shifts right one place; its LSB drops into the vacated top of lo.
               hi  <= {alu_cout, alu_result[XLEN-1:1]};
               lo  <= {alu_result[0], lo[XLEN-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      alu_x    = '0;
      alu_y    = '0;
      alu_ctrl = ALU_ADD;
      if (state == RUN) begin
         alu_x = hi;
         alu_y = lo[0] ? mcand : '0;
      end
   end

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign prod_hi = hi;
   assign prod_lo = lo;

endmodule

`default_nettype wire
